pos_trigger_out: RTL and testbench
==================================

Name: pos_trigger_out

Overview:
Position-triggered output driver, the output-side mirror of the endstop debounce input path. Software arms it with a target position and direction. When the live axis position reaches or passes the target, it drives a timed pulse on a physical output (laser/probe/camera trigger) and records the exact position it fired at. It sits beside the step generator and consumes the same 32-bit signed position bus.

Parameters:
IDLE_LEVEL, 1'b0, output level when not pulsing; the active level is ~IDLE_LEVEL.

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state
pos_in  input  32  current axis position, signed two's complement, valid every cycle
target  input  32  trigger position, signed; sampled only when arm is accepted
dir  input  1  0 = fire when pos_in >= target, 1 = fire when pos_in <= target (signed compares); sampled with target
arm  input  1  single-cycle request to arm
cancel  input  1  single-cycle abort
pulse_len  input  16  active pulse width in clk cycles; 0 is treated as 1
holdoff  input  16  idle cycles forced after a pulse before returning to IDLE
sig_out  output  1  registered trigger output
busy  output  1  high whenever state != IDLE
fired  output  1  sticky flag; set on fire, cleared when the next arm is accepted
fire_pos  output  32  pos_in captured in the cycle the compare hit
cycles  output  8  fire counter; wraps 255 -> 0

Behaviour:
- Reset (async assert): sig_out=IDLE_LEVEL, busy=0, fired=0, fire_pos=0, cycles=0, state=IDLE, internal timer=0, latched target/dir=0.
- States: IDLE, ARMED, PULSE, HOLDOFF. All outputs are registered.
- IDLE: arm=1 latches target and dir, clears fired, and moves to ARMED on the next cycle.
- ARMED:
  - Compare latched target against pos_in every cycle.
  - On a hit in cycle N: fire_pos <= pos_in, fired <= 1, cycles <= cycles+1, timer <= 0, state -> PULSE.
  - sig_out is active from cycle N+1. Latency is exactly 1 clock.
  - arm while ARMED reloads target and dir, and does not fire in that cycle.
  - If the condition is already true at arm acceptance, the block fires on the first ARMED cycle.
- PULSE: sig_out active for exactly max(pulse_len,1) cycles, then sig_out returns to IDLE_LEVEL and the block goes to HOLDOFF with timer reset.
- HOLDOFF:
  - sig_out idle for exactly holdoff cycles, then IDLE.
  - holdoff=0 means PULSE goes straight to IDLE.
- pulse_len and holdoff are sampled live; changing them mid-pulse alters the current pulse length.
- arm in PULSE or HOLDOFF is ignored.
- cancel: from any state, next cycle state=IDLE and sig_out=IDLE_LEVEL. fired, fire_pos and cycles are kept.
- cancel and arm in the same cycle: cancel wins and arm is dropped.
- busy is 1 in ARMED, PULSE and HOLDOFF.
- Reset mid-pulse: output returns to idle immediately (async).
- Compares are full 32-bit signed. Position wrap-around is not treated specially.

Optional Feature:
POS_TRIGGER_REARM_EN
- With the macro: adds input period[31:0] (signed) and input rearm (level, sampled at arm acceptance).
  - If rearm was set, HOLDOFF exit goes to ARMED with target <= target + period (32-bit wrap) instead of IDLE.
  - This gives evenly spaced triggers along a move.
  - cancel still returns to IDLE.
  - fired stays set across re-arms.
- Without the macro: neither port exists, and HOLDOFF always exits to IDLE.

Decomposition:
- Shared package pos_trigger_pkg holds:
  - state encoding constants TRIG_IDLE=0, TRIG_ARMED=1, TRIG_PULSE=2, TRIG_HOLDOFF=3;
  - widths POS_W=32, TIMER_W=16, CNT_W=8.
- One natural sub-module, pos_cmp: a registered-free signed >=/<= comparator selected by dir, reused by future position-compare blocks.
- Everything else stays in a single FSM module.

Test Plan:
- Reset, then arm target=100, dir=0, ramp pos_in 90..110 one step per clock, pulse_len=5, holdoff=3:
  - the compare hits at pos 100; sig_out is high the next cycle for 5 cycles;
  - fire_pos=100, cycles=1, fired=1;
  - busy drops 3 cycles after the pulse ends.
- dir=1, target=-50, pos_in descending from 0 in steps of 7 → fires at pos_in=-56, fire_pos=-56 (signed compare check).
- Arm while pos_in already >= target → sig_out active on the 2nd cycle after arm; pulse_len=0 gives a 1-cycle pulse.
- Assert cancel on the 3rd pulse cycle, pulse_len=10 → sig_out idle the next cycle, state IDLE, cycles unchanged; arm and cancel together → remains IDLE.
- Assert async reset in the middle of PULSE → sig_out=IDLE_LEVEL immediately and all counters are 0.
- With POS_TRIGGER_REARM_EN: target=0, period=20, rearm=1, ramp 0..100 → fires at 0, 20, 40, 60, 80, 100, cycles=6; cancel then stops further pulses.

Source files
------------

// File: rtl/pos_trigger_pkg.sv
// Shared constants for position-triggered output blocks.
// Optional feature macro: POS_TRIGGER_REARM_EN (periodic re-arm).
package pos_trigger_pkg;

  localparam int POS_W   = 32;
  localparam int TIMER_W = 16;
  localparam int CNT_W   = 8;

  localparam logic [1:0] TRIG_IDLE    = 2'd0;
  localparam logic [1:0] TRIG_ARMED   = 2'd1;
  localparam logic [1:0] TRIG_PULSE   = 2'd2;
  localparam logic [1:0] TRIG_HOLDOFF = 2'd3;

  // Pulse width with zero promoted to one; one bit wider so timer+1 never wraps.
  function automatic logic [TIMER_W:0] eff_len(input logic [TIMER_W-1:0] len);
    return (len == '0) ? {{TIMER_W{1'b0}}, 1'b1} : {1'b0, len};
  endfunction

endpackage

// File: rtl/pos_cmp.sv
// Combinational signed position compare: dir=0 -> pos >= target, dir=1 -> pos <= target.
module pos_cmp
  import pos_trigger_pkg::*;
(
  input  logic [POS_W-1:0] pos,
  input  logic [POS_W-1:0] target,
  input  logic             dir,
  output logic             hit
);

  // Direction picks which side of the target counts as reached.
  always_comb begin
    hit = dir ? ($signed(pos) <= $signed(target))
              : ($signed(pos) >= $signed(target));
  end

endmodule

// File: rtl/pos_trigger_out.sv
// Position-triggered pulse output: arm with target/dir, fire a timed pulse
// when the live position reaches the target, then hold off before idling.
// Optional feature macro: POS_TRIGGER_REARM_EN adds period/rearm so that the
// target advances by period after each holdoff and the block re-arms itself.
module pos_trigger_out
  import pos_trigger_pkg::*;
#(
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [POS_W-1:0]   pos_in,
  input  logic [POS_W-1:0]   target,
  input  logic               dir,
  input  logic               arm,
  input  logic               cancel,
  input  logic [TIMER_W-1:0] pulse_len,
  input  logic [TIMER_W-1:0] holdoff,
`ifdef POS_TRIGGER_REARM_EN
  input  logic [POS_W-1:0]   period,
  input  logic               rearm,
`endif
  output logic               sig_out,
  output logic               busy,
  output logic               fired,
  output logic [POS_W-1:0]   fire_pos,
  output logic [CNT_W-1:0]   cycles
);

  logic [1:0]         state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [POS_W-1:0]   tgt_q, tgt_d;
  logic               dir_q, dir_d;
  logic               sig_q, sig_d;
  logic               busy_q, busy_d;
  logic               fired_q, fired_d;
  logic [POS_W-1:0]   fire_pos_q, fire_pos_d;
  logic [CNT_W-1:0]   cycles_q, cycles_d;
  logic               hit;
  logic [TIMER_W:0]   timer_nxt;
  logic               exit_armed;
  logic [POS_W-1:0]   next_tgt;

`ifdef POS_TRIGGER_REARM_EN
  logic rearm_q, rearm_d;
  assign exit_armed = rearm_q;
  assign next_tgt   = tgt_q + period;
`else
  assign exit_armed = 1'b0;
  assign next_tgt   = tgt_q;
`endif

  assign timer_nxt = {1'b0, timer_q} + 1'b1;

  pos_cmp u_cmp (
    .pos    (pos_in),
    .target (tgt_q),
    .dir    (dir_q),
    .hit    (hit)
  );

  // Next-state logic; cancel is applied last so it overrides arm and fire.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    tgt_d      = tgt_q;
    dir_d      = dir_q;
    sig_d      = IDLE_LEVEL;
    fired_d    = fired_q;
    fire_pos_d = fire_pos_q;
    cycles_d   = cycles_q;
`ifdef POS_TRIGGER_REARM_EN
    rearm_d    = rearm_q;
`endif
    case (state_q)
      TRIG_IDLE: begin
        if (arm) begin
          tgt_d   = target;
          dir_d   = dir;
          fired_d = 1'b0;
`ifdef POS_TRIGGER_REARM_EN
          rearm_d = rearm;
`endif
          state_d = TRIG_ARMED;
        end
      end
      TRIG_ARMED: begin
        // A reload cycle never fires; the new target is compared next cycle.
        if (arm) begin
          tgt_d   = target;
          dir_d   = dir;
          fired_d = 1'b0;
`ifdef POS_TRIGGER_REARM_EN
          rearm_d = rearm;
`endif
        end else if (hit) begin
          fire_pos_d = pos_in;
          fired_d    = 1'b1;
          cycles_d   = cycles_q + 1'b1;
          timer_d    = '0;
          sig_d      = ~IDLE_LEVEL;
          state_d    = TRIG_PULSE;
        end
      end
      TRIG_PULSE: begin
        if (timer_nxt >= eff_len(pulse_len)) begin
          timer_d = '0;
          if (holdoff != '0) begin
            state_d = TRIG_HOLDOFF;
          end else if (exit_armed) begin
            state_d = TRIG_ARMED;
            tgt_d   = next_tgt;
          end else begin
            state_d = TRIG_IDLE;
          end
        end else begin
          timer_d = timer_nxt[TIMER_W-1:0];
          sig_d   = ~IDLE_LEVEL;
        end
      end
      default: begin // TRIG_HOLDOFF
        if (timer_nxt >= {1'b0, holdoff}) begin
          timer_d = '0;
          if (exit_armed) begin
            state_d = TRIG_ARMED;
            tgt_d   = next_tgt;
          end else begin
            state_d = TRIG_IDLE;
          end
        end else begin
          timer_d = timer_nxt[TIMER_W-1:0];
        end
      end
    endcase
    if (cancel) begin
      state_d    = TRIG_IDLE;
      sig_d      = IDLE_LEVEL;
      timer_d    = '0;
      tgt_d      = tgt_q;
      dir_d      = dir_q;
      fired_d    = fired_q;
      fire_pos_d = fire_pos_q;
      cycles_d   = cycles_q;
`ifdef POS_TRIGGER_REARM_EN
      rearm_d    = rearm_q;
`endif
    end
    busy_d = (state_d != TRIG_IDLE);
  end

  // State and output registers; reset forces the output idle immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= TRIG_IDLE;
      timer_q    <= '0;
      tgt_q      <= '0;
      dir_q      <= 1'b0;
      sig_q      <= IDLE_LEVEL;
      busy_q     <= 1'b0;
      fired_q    <= 1'b0;
      fire_pos_q <= '0;
      cycles_q   <= '0;
`ifdef POS_TRIGGER_REARM_EN
      rearm_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      tgt_q      <= tgt_d;
      dir_q      <= dir_d;
      sig_q      <= sig_d;
      busy_q     <= busy_d;
      fired_q    <= fired_d;
      fire_pos_q <= fire_pos_d;
      cycles_q   <= cycles_d;
`ifdef POS_TRIGGER_REARM_EN
      rearm_q    <= rearm_d;
`endif
    end
  end

  assign sig_out  = sig_q;
  assign busy     = busy_q;
  assign fired    = fired_q;
  assign fire_pos = fire_pos_q;
  assign cycles   = cycles_q;

endmodule

// File: tb/tb_pos_trigger_out.sv
// Bench for pos_trigger_out: directed stimulus pushes expected fire records
// (position, count, pulse width); a negedge monitor pops and checks them.
// Optional feature macro: POS_TRIGGER_REARM_EN (adds the periodic re-arm test).
module tb_pos_trigger_out;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pos_in;
  logic [31:0] target;
  logic        dir;
  logic        arm;
  logic        cancel;
  logic [15:0] pulse_len;
  logic [15:0] holdoff;
`ifdef POS_TRIGGER_REARM_EN
  logic [31:0] period;
  logic        rearm;
`endif
  logic        sig_out;
  logic        busy;
  logic        fired;
  logic [31:0] fire_pos;
  logic [7:0]  cycles;

  typedef struct {
    logic [31:0] pos;
    logic [7:0]  cnt;
    int          width;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  pos_trigger_out #(.IDLE_LEVEL(1'b0)) dut (
    .clk       (clk),
    .reset     (reset),
    .pos_in    (pos_in),
    .target    (target),
    .dir       (dir),
    .arm       (arm),
    .cancel    (cancel),
    .pulse_len (pulse_len),
    .holdoff   (holdoff),
`ifdef POS_TRIGGER_REARM_EN
    .period    (period),
    .rearm     (rearm),
`endif
    .sig_out   (sig_out),
    .busy      (busy),
    .fired     (fired),
    .fire_pos  (fire_pos),
    .cycles    (cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%h) want %0d (0x%h)", name, act, act, exp, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] p, input logic [7:0] c, input int w);
    exp_t e;
    e.pos = p; e.cnt = c; e.width = w;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      cyc();
      n++;
    end
    chk("wait_idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  // Monitor: a rising output pops a record; the falling edge checks the width.
  logic m_in = 1'b0;
  int   m_w  = 0;
  int   m_ew = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!m_in && sig_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: fire_pos=%0d cycles=%0d want no pulse", $signed(fire_pos), cycles);
      end else begin
        e = exp_q.pop_front();
        chk("sb_fire_pos", fire_pos, e.pos);
        chk("sb_cycles", {24'd0, cycles}, {24'd0, e.cnt});
        chk("sb_fired", {31'd0, fired}, 32'd1);
        m_ew = e.width;
      end
      m_in = 1'b1;
      m_w  = 1;
    end else if (m_in && sig_out === 1'b1) begin
      m_w++;
    end else if (m_in) begin
      chk("sb_pulse_width", m_w, m_ew);
      m_in = 1'b0;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; pos_in = '0; target = '0; dir = 1'b0; arm = 1'b0; cancel = 1'b0;
    pulse_len = '0; holdoff = '0;
`ifdef POS_TRIGGER_REARM_EN
    period = '0; rearm = 1'b0;
`endif
    #3;
    chk("rst_sig_out", {31'd0, sig_out}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_fired", {31'd0, fired}, 32'd0);
    chk("rst_fire_pos", fire_pos, 32'd0);
    chk("rst_cycles", {24'd0, cycles}, 32'd0);
    cyc();
    reset = 1'b0;

    // Ramp 90..110 against target 100, pulse 5, holdoff 3.
    pulse_len = 16'd5; holdoff = 16'd3; target = 32'd100; dir = 1'b0;
    push(32'd100, 8'd1, 5);
    for (int i = 0; i <= 20; i++) begin
      pos_in = 32'(90 + i);
      arm    = (i == 0);
      @(negedge clk);
      if (i == 10) chk("t1_not_yet", {31'd0, sig_out}, 32'd0);
      if (i == 11) chk("t1_latency", {31'd0, sig_out}, 32'd1);
      if (i == 16) chk("t1_pulse_end", {31'd0, sig_out}, 32'd0);
      if (i == 18) chk("t1_busy_holdoff", {31'd0, busy}, 32'd1);
      if (i == 19) chk("t1_busy_drop", {31'd0, busy}, 32'd0);
      cyc();
    end
    arm = 1'b0;
    chk("t1_fire_pos", fire_pos, 32'd100);
    chk("t1_cycles", {24'd0, cycles}, 32'd1);
    chk("t1_fired", {31'd0, fired}, 32'd1);

    // Descending ramp, dir=1, target -50: first hit at -56.
    pulse_len = 16'd4; holdoff = 16'd2; target = 32'hFFFF_FFCE; dir = 1'b1;
    push(32'hFFFF_FFC8, 8'd2, 4);
    for (int i = 0; i <= 14; i++) begin
      pos_in = 32'(-7 * i);
      arm    = (i == 0);
      cyc();
    end
    arm = 1'b0;
    wait_idle(50);
    chk("t2_fire_pos", fire_pos, 32'hFFFF_FFC8);

    // Already past target at arm; pulse_len 0 -> 1-cycle pulse; holdoff 0.
    pos_in = 32'd500; target = 32'd10; dir = 1'b0; pulse_len = 16'd0; holdoff = 16'd0;
    push(32'd500, 8'd3, 1);
    arm = 1'b1;
    cyc();
    arm = 1'b0;
    @(negedge clk);
    chk("t3_armed_busy", {31'd0, busy}, 32'd1);
    chk("t3_armed_sig", {31'd0, sig_out}, 32'd0);
    chk("t3_fired_cleared", {31'd0, fired}, 32'd0);
    cyc();
    @(negedge clk);
    chk("t3_sig_2nd_cycle", {31'd0, sig_out}, 32'd1);
    cyc();
    @(negedge clk);
    chk("t3_one_cycle", {31'd0, sig_out}, 32'd0);
    chk("t3_no_holdoff", {31'd0, busy}, 32'd0);
    cyc();

    // Cancel on the 3rd pulse cycle, then arm+cancel together.
    pulse_len = 16'd10; holdoff = 16'd3;
    push(32'd500, 8'd4, 3);
    arm = 1'b1;
    cyc();
    arm = 1'b0;
    cyc();
    cyc();
    cyc();
    cancel = 1'b1;
    cyc();
    cancel = 1'b0;
    @(negedge clk);
    chk("t4_cancel_sig", {31'd0, sig_out}, 32'd0);
    chk("t4_cancel_busy", {31'd0, busy}, 32'd0);
    chk("t4_cancel_cycles", {24'd0, cycles}, 32'd4);
    chk("t4_cancel_fired", {31'd0, fired}, 32'd1);
    cyc();
    arm = 1'b1; cancel = 1'b1;
    cyc();
    arm = 1'b0; cancel = 1'b0;
    @(negedge clk);
    chk("t4_arm_cancel_idle", {31'd0, busy}, 32'd0);
    chk("t4_arm_cancel_fired", {31'd0, fired}, 32'd1);
    cyc();
    cyc();
    chk("t4_still_idle", {31'd0, busy}, 32'd0);

    // Async reset in the middle of a pulse.
    push(32'd500, 8'd5, 2);
    arm = 1'b1;
    cyc();
    arm = 1'b0;
    cyc();
    cyc();
    cyc();
    reset = 1'b1;
    #1;
    chk("t5_rst_sig", {31'd0, sig_out}, 32'd0);
    chk("t5_rst_busy", {31'd0, busy}, 32'd0);
    chk("t5_rst_cycles", {24'd0, cycles}, 32'd0);
    chk("t5_rst_fired", {31'd0, fired}, 32'd0);
    chk("t5_rst_fire_pos", fire_pos, 32'd0);
    cyc();
    reset = 1'b0;
    cyc();

`ifdef POS_TRIGGER_REARM_EN
    // Periodic re-arm every 20 counts from 0; cancel stops it.
    pulse_len = 16'd2; holdoff = 16'd2; target = 32'd0; dir = 1'b0;
    period = 32'd20; rearm = 1'b1; pos_in = 32'd0;
    for (int k = 0; k < 6; k++) push(32'(20 * k), 8'(k + 1), 2);
    arm = 1'b1;
    cyc();
    arm = 1'b0;
    for (int p = 0; p <= 105; p++) begin
      pos_in = 32'(p);
      cyc();
    end
    cancel = 1'b1;
    cyc();
    cancel = 1'b0;
    for (int p = 106; p <= 130; p++) begin
      pos_in = 32'(p);
      cyc();
    end
    chk("t6_cycles", {24'd0, cycles}, 32'd6);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_fired", {31'd0, fired}, 32'd1);
    rearm = 1'b0;
`endif

    repeat (5) cyc();
    chk("sb_drain", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
